dmem_dump_reader: RTL and testbench

//  Post-run reader for CPU data memory. Waits for the CPU done flag, then reads a window of

---
 rtl/dmem_dump_reader_pkg.sv | 13 +
 rtl/skid_fifo2.sv | 50 +++++
 rtl/dmem_dump_reader.sv | 122 ++++++++++++
 tb/tb_dmem_dump_reader.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_dump_reader_pkg.sv
// Shared types for the post-run data memory dump reader.
package dump_pack;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } dump_state_t;

    localparam int unsigned DUMP_BUF_DEPTH = 2;

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry valid/ready FIFO carrying a {last, data} payload, with occupancy exported so the
// producer can keep reads in flight without ever overflowing it.
module skid_fifo2 #(
    parameter int unsigned W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         valid,
    output logic [1:0]   occupancy
);

    logic [W-1:0] ent_q [2];
    logic         rd_ptr_q;
    logic         wr_ptr_q;
    logic [1:0]   cnt_q;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop & valid;
    // A full buffer still takes a push when the head leaves in the same cycle.
    assign do_push = push & ((cnt_q != 2'd2) | do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_q[0] <= '0;
            ent_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (do_push) begin
                ent_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign head      = ent_q[rd_ptr_q];
    assign valid     = (cnt_q != 2'd0);
    assign occupancy = cnt_q;

endmodule

// File: rtl/dmem_dump_reader.sv
// Post-run data memory dump: on a rising cpu_done edge, reads a window of words in address
// order over the shared read port and streams them out on a valid/ready byte interface.
module dmem_dump_reader
    import dump_pack::*;
#(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          start,
    input  logic          cpu_done,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   count,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic          dout_last,
    output logic          dump_busy,
    output logic          dump_done
);

    dump_state_t   state_q;
    logic          cpu_done_q;
    logic [AW-1:0] addr_q;
    logic [AW:0]   remain_q;
    logic          rd_pend_q;
    logic          rd_pend_last_q;

    logic [1:0]    buf_occ;
    logic [2:0]    occ;
    logic [DW:0]   head;
    logic          pop;
    logic          issue;
    logic          last_issue;
    logic          trigger;

    assign pop = dout_valid & dout_ready;
    // Occupancy as it stands after this cycle's transfer, so a departing word admits a new
    // read in the same cycle and a held-ready sink sees one word per cycle.
    assign occ        = {1'b0, buf_occ} + {2'b00, rd_pend_q} - {2'b00, pop};
    assign issue      = (state_q == READ) && (occ < 3'(DUMP_BUF_DEPTH));
    assign last_issue = (remain_q == (AW+1)'(1));
    assign trigger    = cpu_done & ~cpu_done_q;

    assign mem_rd_en = issue;
    assign mem_addr  = addr_q;

    always_ff @(posedge clk or posedge start) begin
        if (start) begin
            state_q        <= IDLE;
            cpu_done_q     <= 1'b0;
            addr_q         <= '0;
            remain_q       <= '0;
            rd_pend_q      <= 1'b0;
            rd_pend_last_q <= 1'b0;
            dump_busy      <= 1'b0;
            dump_done      <= 1'b0;
        end else begin
            cpu_done_q     <= cpu_done;
            rd_pend_q      <= issue;
            rd_pend_last_q <= issue & last_issue;
            case (state_q)
                IDLE: begin
                    if (trigger) begin
                        if (count == '0) begin
                            state_q   <= DONE;
                            dump_done <= 1'b1;
                        end else begin
                            state_q   <= READ;
                            addr_q    <= base_addr;
                            remain_q  <= count;
                            dump_busy <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (issue) begin
                        addr_q   <= addr_q + AW'(1);
                        remain_q <= remain_q - (AW+1)'(1);
                        if (last_issue) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (occ == 3'd0) begin
                        state_q   <= DONE;
                        dump_busy <= 1'b0;
                        dump_done <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= DONE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Read data lands one cycle after the strobe and is captured with its last tag.
    skid_fifo2 #(
        .W(DW + 1)
    ) u_buf (
        .clk       (clk),
        .rst       (start),
        .push      (rd_pend_q),
        .push_data ({rd_pend_last_q, mem_rdata}),
        .pop       (dout_ready),
        .head      (head),
        .valid     (dout_valid),
        .occupancy (buf_occ)
    );

    assign dout      = head[DW-1:0];
    assign dout_last = dout_valid & head[DW];

endmodule

// File: tb/tb_dmem_dump_reader.sv
// Directed bench for dmem_dump_reader with a synchronous-read data memory model.
module tb_dmem_dump_reader;

    localparam int AW = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          start;
    logic          cpu_done;
    logic [AW-1:0] base_addr;
    logic [AW:0]   count;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;
    logic          dout_last;
    logic          dump_busy;
    logic          dump_done;

    logic [7:0] mem [256];
    logic [7:0] expw [8];
    logic [7:0] rx_data [$];
    logic       rx_last [$];
    logic [7:0] rd_addrs [$];
    int         stall_bad;
    int         occ_bad;
    bit         finished;
    int         checks = 0;
    int         errors = 0;

    dmem_dump_reader #(
        .AW(AW),
        .DW(DW)
    ) dut (
        .clk        (clk),
        .start      (start),
        .cpu_done   (cpu_done),
        .base_addr  (base_addr),
        .count      (count),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last),
        .dump_busy  (dump_busy),
        .dump_done  (dump_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        start      = 1'b1;
        cpu_done   = 1'b0;
        dout_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
    endtask

    // Runs a dump to completion (or budget), recording accepted words and issued addresses.
    task automatic collect(input int budget, input bit toggle);
        int         outstanding = 0;
        logic [7:0] held = 8'h00;
        bit         held_v = 1'b0;
        bit         acc;
        rx_data.delete();
        rx_last.delete();
        rd_addrs.delete();
        stall_bad = 0;
        occ_bad   = 0;
        finished  = 1'b0;
        for (int c = 0; c < budget && !finished; c++) begin
            @(negedge clk);
            dout_ready = toggle ? (c % 3 == 0) : 1'b1;
            #1;
            if (held_v && (!dout_valid || dout !== held)) stall_bad++;
            acc = dout_valid && dout_ready;
            if (outstanding + int'(mem_rd_en) - int'(acc) > 2) occ_bad++;
            if (mem_rd_en) rd_addrs.push_back(mem_addr);
            if (acc) begin
                rx_data.push_back(dout);
                rx_last.push_back(dout_last);
            end
            held_v = dout_valid && !dout_ready;
            held   = dout;
            outstanding += int'(mem_rd_en) - int'(acc);
            if (dump_done) finished = 1'b1;
        end
        dout_ready = 1'b1;
    endtask

    task automatic chk_stream(input string tag, input int n);
        chk({tag, "_nwords"}, rx_data.size(), n);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_word%0d", tag, i),
                (i < rx_data.size()) ? {24'h0, rx_data[i]} : 32'hBAD, {24'h0, expw[i]});
            chk($sformatf("%s_last%0d", tag, i),
                (i < rx_last.size()) ? {31'h0, rx_last[i]} : 32'hBAD, (i == n - 1) ? 1 : 0);
        end
    endtask

    initial begin
        int nrd;
        int nvld;
        int nacc;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0]   = 8'h0F;
        mem[1]   = 8'h0C;
        mem[2]   = 8'h00;
        mem[3]   = 8'h1B;
        mem[4]   = 8'hFA;
        mem[254] = 8'hA1;
        mem[255] = 8'hB2;
        mem_rdata  = 8'h00;
        start      = 1'b1;
        cpu_done   = 1'b0;
        dout_ready = 1'b1;
        base_addr  = 8'h00;
        count      = 9'd5;

        // Reset values
        @(negedge clk);
        #1;
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_dout", dout, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_last", dout_last, 0);
        chk("rst_busy", dump_busy, 0);
        chk("rst_done", dump_done, 0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);

        // Test 1: full-rate dump of five words, cycle exact
        expw = '{8'h0F, 8'h0C, 8'h00, 8'h1B, 8'hFA, 8'h00, 8'h00, 8'h00};
        chk("t1_idle_done", dump_done, 0);
        cpu_done = 1'b1;
        @(negedge clk);
        chk("t1_busy", dump_busy, 1);
        chk("t1_rd_en0", mem_rd_en, 1);
        chk("t1_addr0", mem_addr, 0);
        @(negedge clk);
        chk("t1_no_valid_yet", dout_valid, 0);
        chk("t1_addr1", mem_addr, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("t1_valid%0d", i), dout_valid, 1);
            chk($sformatf("t1_dout%0d", i), dout, expw[i]);
            chk($sformatf("t1_last%0d", i), dout_last, (i == 4) ? 1 : 0);
            chk($sformatf("t1_done_early%0d", i), dump_done, 0);
        end
        @(negedge clk);
        chk("t1_done", dump_done, 1);
        chk("t1_valid_after", dout_valid, 0);
        chk("t1_busy_after", dump_busy, 0);

        // Test 6: further cpu_done edges in DONE are ignored
        cpu_done = 1'b0;
        repeat (2) @(negedge clk);
        cpu_done = 1'b1;
        nrd  = 0;
        nvld = 0;
        repeat (5) begin
            @(negedge clk);
            if (mem_rd_en) nrd++;
            if (dout_valid) nvld++;
        end
        chk("t6_no_reads", nrd, 0);
        chk("t6_no_valid", nvld, 0);
        chk("t6_done", dump_done, 1);
        chk("t6_busy", dump_busy, 0);

        // Test 2: sink stalls with ready pattern 1,0,0
        do_reset();
        base_addr = 8'h00;
        count     = 9'd5;
        cpu_done  = 1'b1;
        collect(80, 1'b1);
        chk("t2_finished", finished, 1);
        chk("t2_stall_stable", stall_bad, 0);
        chk("t2_occupancy", occ_bad, 0);
        chk_stream("t2", 5);

        // Test 3: empty dump
        do_reset();
        count = 9'd0;
        chk("t3_done_before", dump_done, 0);
        cpu_done = 1'b1;
        @(negedge clk);
        chk("t3_done", dump_done, 1);
        chk("t3_rd_en", mem_rd_en, 0);
        chk("t3_valid", dout_valid, 0);
        chk("t3_busy", dump_busy, 0);
        nrd  = 0;
        nvld = 0;
        repeat (3) begin
            @(negedge clk);
            if (mem_rd_en) nrd++;
            if (dout_valid) nvld++;
        end
        chk("t3_no_reads", nrd, 0);
        chk("t3_no_valid", nvld, 0);

        // Test 4: address wrap past the top of memory
        do_reset();
        base_addr = 8'hFE;
        count     = 9'd4;
        expw      = '{8'hA1, 8'hB2, 8'h0F, 8'h0C, 8'h00, 8'h00, 8'h00, 8'h00};
        cpu_done  = 1'b1;
        collect(40, 1'b0);
        chk("t4_finished", finished, 1);
        chk("t4_nreads", rd_addrs.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t4_addr%0d", i),
                (i < rd_addrs.size()) ? {24'h0, rd_addrs[i]} : 32'hBAD,
                (32'hFE + i) & 32'hFF);
        end
        chk_stream("t4", 4);

        // Test 5: async abort after two words, then a fresh dump
        do_reset();
        base_addr = 8'h00;
        count     = 9'd5;
        expw      = '{8'h0F, 8'h0C, 8'h00, 8'h1B, 8'hFA, 8'h00, 8'h00, 8'h00};
        cpu_done  = 1'b1;
        nacc      = 0;
        for (int c = 0; c < 20 && nacc < 2; c++) begin
            @(negedge clk);
            #1;
            if (dout_valid && dout_ready) nacc++;
        end
        chk("t5_two_words", nacc, 2);
        @(posedge clk);
        #2;
        chk("t5_busy_mid", dump_busy, 1);
        start = 1'b1;
        #1;
        chk("t5_rd_en", mem_rd_en, 0);
        chk("t5_addr", mem_addr, 0);
        chk("t5_dout", dout, 0);
        chk("t5_valid", dout_valid, 0);
        chk("t5_last", dout_last, 0);
        chk("t5_busy", dump_busy, 0);
        chk("t5_done", dump_done, 0);
        @(negedge clk);
        start = 1'b0;
        collect(40, 1'b0);
        chk("t5_finished", finished, 1);
        chk("t5_first_addr", (rd_addrs.size() > 0) ? {24'h0, rd_addrs[0]} : 32'hBAD, 0);
        chk_stream("t5", 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
